// File: rtl/sample_burst_gen.sv
// Burst source and self-checker for the sample-averaging datapath: emits a dvalid burst,
// divides the sum to get the expected average, then compares it with avg_in. Build option: SAMPLE_GEN_LFSR_EN.
module sample_burst_gen #(
    parameter int WIDTH          = 8,
    parameter int MAX_SAMPLES    = 1000,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int CNT_WIDTH     = $clog2(MAX_SAMPLES + 1),
    localparam int SUM_WIDTH     = WIDTH + CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] burst_len,
    input  logic [WIDTH-1:0]     seed,
    output logic [WIDTH-1:0]     data_out,
    output logic                 dvalid_out,
    input  logic [WIDTH-1:0]     avg_in,
    input  logic                 avg_valid_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [WIDTH-1:0]     exp_avg
);

    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DIVC_W = $clog2(SUM_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, SEND, DIV, WAIT_AVG, REPORT} state_t;

`ifdef SAMPLE_GEN_LFSR_EN
    function automatic logic [31:0] taps_for(input int w);
        case (w)
            3:       return 32'h6;
            4:       return 32'hC;
            5:       return 32'h14;
            6:       return 32'h30;
            7:       return 32'h60;
            8:       return 32'hB8;
            9:       return 32'h110;
            10:      return 32'h240;
            11:      return 32'h500;
            12:      return 32'hE08;
            13:      return 32'h1C80;
            14:      return 32'h3802;
            15:      return 32'h6000;
            default: return 32'hB400;
        endcase
    endfunction

    localparam logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(taps_for(WIDTH));

    function automatic logic [WIDTH-1:0] next_sample(input logic [WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] first_sample(input logic [WIDTH-1:0] s);
        return (s == '0) ? WIDTH'(1) : s;
    endfunction
`else
    function automatic logic [WIDTH-1:0] next_sample(input logic [WIDTH-1:0] s);
        return s + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] first_sample(input logic [WIDTH-1:0] s);
        return s;
    endfunction
`endif

    state_t                 state;
    logic [CNT_WIDTH-1:0]   len_r;
    logic [CNT_WIDTH-1:0]   idx;
    logic [SUM_WIDTH-1:0]   sum;
    logic [SUM_WIDTH-1:0]   quo;
    logic [CNT_WIDTH-1:0]   rem;
    logic [DIVC_W-1:0]      div_cnt;
    logic [TMO_W-1:0]       tcnt;
    logic                   tmo_hit;
    logic                   avg_got;
    logic [WIDTH-1:0]       avg_lat;

    logic [CNT_WIDTH:0]     trial;
    logic [CNT_WIDTH-1:0]   rem_next;
    logic [SUM_WIDTH-1:0]   quo_next;
    logic [SUM_WIDTH-1:0]   sum_next;
    logic                   tmo_now;
    logic                   avg_have;
    logic [WIDTH-1:0]       avg_now;

    // One restoring-division step: the dividend shifts out of quo's MSB as quotient bits shift in.
    always_comb begin
        trial    = {rem, quo[SUM_WIDTH-1]};
        rem_next = trial[CNT_WIDTH-1:0];
        quo_next = {quo[SUM_WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, len_r}) begin
            rem_next = CNT_WIDTH'(trial - {1'b0, len_r});
            quo_next = {quo[SUM_WIDTH-2:0], 1'b1};
        end
        sum_next = sum + SUM_WIDTH'(data_out);
        tmo_now  = tmo_hit || (tcnt == TMO_W'(TIMEOUT_CYCLES - 1));
        avg_have = avg_got || avg_valid_in;
        avg_now  = avg_got ? avg_lat : avg_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            len_r      <= '0;
            idx        <= '0;
            sum        <= '0;
            quo        <= '0;
            rem        <= '0;
            div_cnt    <= '0;
            tcnt       <= '0;
            tmo_hit    <= 1'b0;
            avg_got    <= 1'b0;
            avg_lat    <= '0;
            data_out   <= '0;
            dvalid_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            exp_avg    <= '0;
        end else begin
            done <= 1'b0;
            // Timeout counter and avg capture run across both DIV and WAIT_AVG.
            if (state == DIV || state == WAIT_AVG) begin
                if (!tmo_hit) begin
                    tcnt <= tcnt + TMO_W'(1);
                    if (tcnt == TMO_W'(TIMEOUT_CYCLES - 1)) tmo_hit <= 1'b1;
                end
                if (avg_valid_in && !avg_got) begin
                    avg_got <= 1'b1;
                    avg_lat <= avg_in;
                end
            end
            case (state)
                IDLE: begin
                    if (start && burst_len != '0) begin
                        state      <= SEND;
                        len_r      <= burst_len;
                        idx        <= '0;
                        sum        <= '0;
                        pass       <= 1'b0;
                        timeout    <= 1'b0;
                        exp_avg    <= '0;
                        busy       <= 1'b1;
                        dvalid_out <= 1'b1;
                        data_out   <= first_sample(seed);
                        avg_got    <= 1'b0;
                        tmo_hit    <= 1'b0;
                    end
                end
                SEND: begin
                    sum <= sum_next;
                    idx <= idx + CNT_WIDTH'(1);
                    if (idx == len_r - CNT_WIDTH'(1)) begin
                        state      <= DIV;
                        dvalid_out <= 1'b0;
                        data_out   <= '0;
                        quo        <= sum_next;
                        rem        <= '0;
                        div_cnt    <= '0;
                        tcnt       <= '0;
                    end else begin
                        data_out <= next_sample(data_out);
                    end
                end
                DIV: begin
                    quo     <= quo_next;
                    rem     <= rem_next;
                    div_cnt <= div_cnt + DIVC_W'(1);
                    if (div_cnt == DIVC_W'(SUM_WIDTH - 1)) begin
                        state   <= WAIT_AVG;
                        exp_avg <= quo_next[WIDTH-1:0];
                    end
                end
                WAIT_AVG: begin
                    if (avg_have) begin
                        state <= REPORT;
                        pass  <= (avg_now == exp_avg);
                        done  <= 1'b1;
                    end else if (tmo_now) begin
                        state   <= REPORT;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                REPORT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_burst_gen.sv
// Directed bench for sample_burst_gen (default ramp pattern, WIDTH=8, TIMEOUT_CYCLES=64).
module tb_sample_burst_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] burst_len;
    logic [7:0] seed;
    logic [7:0] data_out;
    logic       dvalid_out;
    logic [7:0] avg_in;
    logic       avg_valid_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic       timeout;
    logic [7:0] exp_avg;

    int checks   = 0;
    int failures = 0;

    sample_burst_gen #(.WIDTH(8), .MAX_SAMPLES(1000), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .seed(seed),
        .data_out(data_out), .dvalid_out(dvalid_out), .avg_in(avg_in),
        .avg_valid_in(avg_valid_in), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .exp_avg(exp_avg)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the start cycle; cycle c is the c-th clock period after it.
    typedef struct {
        int seed;
        int len;
        int avg_c;     // cycle avg_valid_in is driven (0 = never)
        int avg;
        int pre_c;     // cycle a bogus avg_valid_in is driven during SEND (0 = none)
        int dup_c;     // cycle a second start is pulsed while busy (0 = none)
        int exp_avg;
        int exp_pass;
        int exp_to;
        int exp_done;  // cycle done is expected high
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int c, done_c, dv_cnt, data_err, done_cnt, busy_at_done, busy_after;
        logic [7:0] m;
        @(negedge clk);
        start     = 1'b1;
        burst_len = 10'(v.len);
        seed      = 8'(v.seed);
        c = 0; done_c = -1; dv_cnt = 0; data_err = 0; done_cnt = 0;
        busy_at_done = -1; busy_after = -1;
        while (c < 200 && (done_c < 0 || c < done_c + 3)) begin
            @(negedge clk);
            c++;
            start        = 1'b0;
            avg_valid_in = 1'b0;
            avg_in       = '0;
            if (dvalid_out) begin
                dv_cnt++;
                m = 8'(v.seed) + 8'(dv_cnt - 1);
                if (data_out !== m || c != dv_cnt) data_err++;
            end
            if (done) begin
                done_cnt++;
                if (done_c < 0) begin
                    done_c = c;
                    busy_at_done = int'(busy);
                end
            end
            if (done_c >= 0 && c == done_c + 1) busy_after = int'(busy);
            if (c == v.pre_c) begin avg_valid_in = 1'b1; avg_in = 8'hAA; end
            if (c == v.avg_c) begin avg_valid_in = 1'b1; avg_in = 8'(v.avg); end
            if (c == v.dup_c) begin start = 1'b1; burst_len = 10'd9; seed = 8'd0; end
        end
        check($sformatf("v%0d_dvalid_count", n), dv_cnt, v.len);
        check($sformatf("v%0d_data_pattern_errs", n), data_err, 0);
        check($sformatf("v%0d_done_cycle", n), done_c, v.exp_done);
        check($sformatf("v%0d_done_pulses", n), done_cnt, 1);
        check($sformatf("v%0d_busy_at_done", n), busy_at_done, 1);
        check($sformatf("v%0d_busy_after_done", n), busy_after, 0);
        check($sformatf("v%0d_exp_avg", n), int'(exp_avg), v.exp_avg);
        check($sformatf("v%0d_pass", n), int'(pass), v.exp_pass);
        check($sformatf("v%0d_timeout", n), int'(timeout), v.exp_to);
    endtask

    initial begin
        int dv_seen, busy_seen, done_seen;
        vec_t post;

        //          seed len avg_c avg pre dup exp pass to done
        vecs[0] = '{10,  4,  23,  11,  0,  0,  11,  1,  0,  24};
        vecs[1] = '{254, 4,  23,  127, 0,  0,  127, 1,  0,  24};
        vecs[2] = '{10,  4,  6,   12,  0,  0,  11,  0,  0,  24};
        vecs[3] = '{5,   1,  0,   0,   0,  0,  5,   0,  1,  66};
        vecs[4] = '{5,   1,  65,  5,   0,  0,  5,   1,  0,  66};
        vecs[5] = '{100, 3,  40,  101, 0,  3,  101, 1,  0,  41};
        vecs[6] = '{255, 2,  21,  127, 2,  0,  127, 1,  0,  22};
        post    = '{0,   2,  21,  0,   0,  0,  0,   1,  0,  22};

        rst = 1'b1; start = 1'b0; burst_len = '0; seed = '0;
        avg_in = '0; avg_valid_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_dvalid", int'(dvalid_out), 0);
        check("reset_data", int'(data_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_pass", int'(pass), 0);
        check("reset_timeout", int'(timeout), 0);
        check("reset_exp_avg", int'(exp_avg), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Zero-length start is ignored.
        @(negedge clk);
        start = 1'b1; burst_len = '0; seed = 8'd7;
        dv_seen = 0; busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (dvalid_out) dv_seen++;
            if (busy) busy_seen++;
        end
        check("len0_dvalid_cycles", dv_seen, 0);
        check("len0_busy_cycles", busy_seen, 0);

        // Asynchronous reset on the 3rd sample of an 8-sample burst.
        @(negedge clk);
        start = 1'b1; burst_len = 10'd8; seed = 8'd20;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_burst_dvalid", int'(dvalid_out), 1);
        check("mid_burst_data", int'(data_out), 22);
        rst = 1'b1;
        #1;
        check("async_rst_dvalid", int'(dvalid_out), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || dvalid_out || busy) done_seen++;
        end
        check("post_rst_quiet_cycles", done_seen, 0);
        run_vec(7, post);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_burst_gen.md
Name: sample_burst_gen

Overview:
- Stream source and self-checker for the sample-averaging datapath; drives the other end of the data/dvalid burst interface.
- On start, emits one contiguous dvalid burst of programmable length, then drops dvalid to close the burst.
- Computes the expected floor average with a multicycle restoring divider, waits for the averager's avg_valid, and compares the result.
- Used in block-level benches and in the on-chip BIST wrapper.

Parameters:
- WIDTH, 8, sample and average width.
- MAX_SAMPLES, 1000, maximum burst length. CNT_WIDTH = $clog2(MAX_SAMPLES+1). SUM_WIDTH = WIDTH + CNT_WIDTH.
- TIMEOUT_CYCLES, 64, cycles allowed from end of burst to avg_valid_in.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a burst.
- burst_len  in  CNT_WIDTH  number of samples; sampled when start is accepted.
- seed  in  WIDTH  first sample value; sampled when start is accepted.
- data_out  out  WIDTH  sample to the averager.
- dvalid_out  out  1  sample valid; high for exactly burst_len consecutive cycles.
- avg_in  in  WIDTH  average returned by the averager.
- avg_valid_in  in  1  average valid from the averager.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of check.
- pass  out  1  result of the last check; held until the next start.
- timeout  out  1  last check ended by timeout; held until the next start.
- exp_avg  out  WIDTH  expected average; held until the next start.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; internal sum, counters, divider and latched average cleared. Reset mid-burst drops dvalid_out immediately; no done pulse is produced.
- States: IDLE, SEND, DIV, WAIT_AVG, REPORT.
- IDLE:
  - start=1 and burst_len!=0 → SEND. Latch burst_len and seed; clear sum, pass, timeout and exp_avg; set busy=1.
  - start=1 with burst_len==0 → ignored; stay IDLE.
- start is ignored in every state other than IDLE.
- SEND:
  - dvalid_out=1 and data_out=current sample on every SEND cycle. The first sample appears the cycle after start.
  - sum += zero-extended sample; sample index increments.
  - After burst_len samples → DIV. dvalid_out is 0 from the first DIV cycle, so the burst is contiguous with no bubbles.
- Sample pattern (default): sample i = (seed + i) mod 2^WIDTH, wrapping silently.
- DIV:
  - Restoring division of sum by burst_len, one quotient bit per cycle, exactly SUM_WIDTH cycles.
  - Then → WAIT_AVG; exp_avg = quotient[WIDTH-1:0]. The quotient never exceeds 2^WIDTH-1.
- Timeout counter starts at 0 on the first DIV cycle and increments on every cycle in DIV and WAIT_AVG.
- avg_valid_in is monitored in both DIV and WAIT_AVG. On its first high cycle, avg_in is latched; later assertions are ignored.
- WAIT_AVG:
  - If an average is latched, or avg_valid_in=1 this cycle (same-cycle latch is allowed) → REPORT; pass = (latched avg == exp_avg).
  - Else if the timeout counter reaches TIMEOUT_CYCLES → REPORT; timeout=1, pass=0.
  - If avg_valid_in and the timeout limit coincide in the same cycle, the valid average wins.
- If the timeout limit is reached while still in DIV, the timeout is recorded and takes effect on entry to WAIT_AVG unless an average is already latched.
- REPORT: done=1 for one cycle; busy=0 on the next cycle; → IDLE.
- Latency from start to the first dvalid_out is 1 cycle. Minimum start-to-done is 1 + burst_len + SUM_WIDTH + 1 cycles.
- An avg_valid_in that is still high from a previous burst is not seen during IDLE or SEND.

Optional Feature:
- Macro SAMPLE_GEN_LFSR_EN.
- Defined: samples come from a WIDTH-bit Galois LFSR (maximal-length taps per WIDTH).
  - The LFSR is loaded with seed at start; seed==0 is replaced by 1.
  - Sample i is the LFSR state after i advances.
  - Sum, divide and compare are unchanged.
- Not defined: ramp pattern as above; no LFSR logic is synthesized.

Test Plan:
- WIDTH=8, seed=10, burst_len=4; averager returns 11 → data_out 10,11,12,13 on 4 consecutive cycles; exp_avg=11, pass=1, done pulses once.
- seed=254, burst_len=4 → samples 254,255,0,1; sum 510; exp_avg=127; avg_in=127 gives pass=1.
- seed=10, burst_len=4; avg_in=12 asserted on the 2nd DIV cycle → latched; done after DIV; pass=0, timeout=0, exp_avg=11.
- seed=5, burst_len=1; avg_valid_in never asserted → done exactly TIMEOUT_CYCLES cycles after the first DIV cycle; timeout=1, pass=0.
- start with burst_len=0 → dvalid_out stays 0 and busy stays 0. start pulsed while busy → ignored; burst length and done count unchanged.
- rst asserted on the 3rd sample of burst_len=8 → dvalid_out, busy and done drop to 0 asynchronously. A new start (seed=0, burst_len=2) gives a clean burst 0,1, exp_avg=0.
